// File: rtl/dram_access_arbiter.sv
// DRAM access arbiter: decodes CPU strobes for the DRAM window, times refresh,
// and hands out one-at-a-time CPU/refresh grants to the DRAM controller.
module dram_access_arbiter #(
  parameter int          REFRESH_INTERVAL = 125,
  parameter int          MAX_PENDING      = 4,
  parameter logic [23:0] DRAM_BASE        = 24'h000000,
  parameter logic [23:0] DRAM_MASK        = 24'hE00000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        AS,
  input  logic [23:0] ADDR_IN,
  input  logic        DONE,
  output logic        CPU_GO,
  output logic        REF_GO,
  output logic        DRAM_SEL,
  output logic [2:0]  REF_PENDING,
  output logic        OVERRUN
);

  localparam int            CW   = $clog2(REFRESH_INTERVAL);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_INTERVAL - 1);
  localparam logic [2:0]    PMAX = 3'(MAX_PENDING);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CPU,
    S_REF,
    S_HOLD
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] ival_q;
  logic          tick;
  logic          ref_done;
  logic          sat;

  assign tick     = (ival_q == LAST);
  assign ref_done = (state_q == S_REF) && DONE;
  assign sat      = (REF_PENDING == PMAX);

  always_ff @(posedge CLK) begin
    if (RST) begin
      ival_q <= '0;
    end else if (tick) begin
      ival_q <= '0;
    end else begin
      ival_q <= ival_q + 1'b1;
    end
  end

  // A tick and a completed refresh in the same cycle cancel out
  always_ff @(posedge CLK) begin
    if (RST) begin
      REF_PENDING <= 3'd0;
      OVERRUN     <= 1'b0;
    end else if (tick && !ref_done) begin
      if (sat) begin
        OVERRUN <= 1'b1;
      end else begin
        REF_PENDING <= REF_PENDING + 3'd1;
      end
    end else if (ref_done && !tick) begin
      REF_PENDING <= REF_PENDING - 3'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      DRAM_SEL <= 1'b0;
    end else begin
      DRAM_SEL <= !AS && ((ADDR_IN & DRAM_MASK) == DRAM_BASE);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (sat) begin
          state_d = S_REF;
        end else if (DRAM_SEL) begin
          state_d = S_CPU;
        end else if ((REF_PENDING != 3'd0) && AS) begin
          state_d = S_REF;
        end
      end
      S_CPU: begin
        if (DONE) state_d = S_HOLD;
      end
      S_REF: begin
        if (DONE) state_d = S_IDLE;
      end
      S_HOLD: begin
        // Stay off the bus until the granted cycle's strobe is released
        if (AS) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      CPU_GO  <= 1'b0;
      REF_GO  <= 1'b0;
    end else begin
      state_q <= state_d;
      CPU_GO  <= (state_d == S_CPU);
      REF_GO  <= (state_d == S_REF);
    end
  end

endmodule

// File: tb/tb_dram_access_arbiter.sv
// Self-checking bench for dram_access_arbiter: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_dram_access_arbiter;

  localparam int RI = 16;
  localparam int MP = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        AS;
  logic [23:0] ADDR_IN;
  logic        DONE;
  logic        CPU_GO;
  logic        REF_GO;
  logic        DRAM_SEL;
  logic [2:0]  REF_PENDING;
  logic        OVERRUN;

  dram_access_arbiter #(
    .REFRESH_INTERVAL(RI),
    .MAX_PENDING(MP),
    .DRAM_BASE(24'h000000),
    .DRAM_MASK(24'hE00000)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .AS(AS),
    .ADDR_IN(ADDR_IN),
    .DONE(DONE),
    .CPU_GO(CPU_GO),
    .REF_GO(REF_GO),
    .DRAM_SEL(DRAM_SEL),
    .REF_PENDING(REF_PENDING),
    .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: owner 0 = nobody, 1 = CPU, 2 = refresh
  int m_cnt  = 0;
  int m_pend = 0;
  bit m_ovr  = 0;
  bit m_sel  = 0;
  int m_own  = 0;
  bit m_hold = 0;

  function automatic bit in_window(input logic [23:0] a);
    return (a >= 24'h000000) && (a < 24'h200000);
  endfunction

  function automatic void model_step();
    bit tick;
    bit dec;
    int own_n;
    bit hold_n;
    if (RST) begin
      m_cnt = 0; m_pend = 0; m_ovr = 0;
      m_sel = 0; m_own = 0; m_hold = 0;
      return;
    end
    tick   = (m_cnt == RI - 1);
    dec    = (m_own == 2) && DONE;
    own_n  = m_own;
    hold_n = m_hold;
    if (m_own == 1) begin
      if (DONE) begin own_n = 0; hold_n = 1; end
    end else if (m_own == 2) begin
      if (DONE) own_n = 0;
    end else if (m_hold) begin
      if (AS) hold_n = 0;
    end else if (m_pend == MP) begin
      own_n = 2;
    end else if (m_sel) begin
      own_n = 1;
    end else if (m_pend > 0 && AS) begin
      own_n = 2;
    end
    if (tick && !dec) begin
      if (m_pend == MP) m_ovr = 1;
      else m_pend = m_pend + 1;
    end else if (dec && !tick) begin
      m_pend = m_pend - 1;
    end
    m_own  = own_n;
    m_hold = hold_n;
    m_sel  = !AS && in_window(ADDR_IN);
    m_cnt  = (m_cnt + 1) % RI;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_step();
    #1;
    chk("cpu_go", 32'(CPU_GO), 32'(m_own == 1));
    chk("ref_go", 32'(REF_GO), 32'(m_own == 2));
    chk("dram_sel", 32'(DRAM_SEL), 32'(m_sel));
    chk("ref_pending", 32'(REF_PENDING), 32'(m_pend));
    chk("overrun", 32'(OVERRUN), 32'(m_ovr));
    chk("exclusive", 32'(CPU_GO & REF_GO), 32'd0);
  endtask

  task automatic drain(input int budget, output int nref);
    int i;
    i    = 0;
    nref = 0;
    AS   = 1'b1;
    while (i < budget && (REF_PENDING != 3'd0 || REF_GO || CPU_GO)) begin
      DONE = REF_GO | CPU_GO;
      if (REF_GO) nref++;
      cyc();
      DONE = 1'b0;
      i++;
    end
    chk("drain_in_budget", 32'(i < budget), 32'd1);
  endtask

  initial begin
    int n;
    int nref;
    int p;
    bit slow;

    RST = 1'b1; AS = 1'b0; ADDR_IN = 24'h120034; DONE = 1'b0;
    cyc();
    cyc();
    chk("reset_outputs",
        32'({CPU_GO, REF_GO, DRAM_SEL, REF_PENDING, OVERRUN}), 32'd0);

    // Refresh interval restarts on release; idle refresh
    RST = 1'b0; AS = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (REF_PENDING == 3'd0 && n < 40);
    chk("first_tick_cycles", 32'(n), 32'(RI));
    cyc();
    chk("idle_ref_go", 32'(REF_GO), 32'd1);
    DONE = 1'b1; cyc(); DONE = 1'b0;
    chk("idle_ref_released", 32'(REF_GO), 32'd0);
    chk("idle_ref_pend", 32'(REF_PENDING), 32'd0);

    // CPU hit latency and hold-off
    ADDR_IN = 24'h120034; AS = 1'b0;
    cyc();
    chk("hit_sel_lat", 32'(DRAM_SEL), 32'd1);
    chk("hit_go_early", 32'(CPU_GO), 32'd0);
    cyc();
    chk("hit_go_lat", 32'(CPU_GO), 32'd1);
    cyc();
    cyc();
    DONE = 1'b1; cyc(); DONE = 1'b0;
    chk("hit_go_released", 32'(CPU_GO), 32'd0);
    repeat (4) begin
      cyc();
      chk("hold_no_regrant", 32'(CPU_GO), 32'd0);
    end
    AS = 1'b1;
    cyc();
    cyc();

    // Miss
    ADDR_IN = 24'hE00000; AS = 1'b0;
    repeat (30) begin
      cyc();
      chk("miss_sel", 32'(DRAM_SEL), 32'd0);
      chk("miss_go", 32'(CPU_GO), 32'd0);
    end
    drain(200, nref);

    // Saturation while a CPU grant is held
    ADDR_IN = 24'h000100; AS = 1'b0;
    n = 0;
    while (!CPU_GO && n < 40) begin cyc(); n++; end
    chk("sat_cpu_grant", 32'(CPU_GO), 32'd1);
    repeat (80) cyc();
    chk("sat_pending", 32'(REF_PENDING), 32'(MP));
    chk("sat_overrun", 32'(OVERRUN), 32'd1);
    DONE = 1'b1; cyc(); DONE = 1'b0;
    AS = 1'b1; cyc();
    AS = 1'b0; ADDR_IN = 24'h000200;
    n = 0;
    while (!CPU_GO && !REF_GO && n < 10) begin cyc(); n++; end
    chk("sat_ref_first", 32'(REF_GO), 32'd1);
    chk("sat_cpu_waits", 32'(CPU_GO), 32'd0);
    drain(200, nref);
    chk("sat_ref_count", 32'(nref >= MP), 32'd1);
    chk("sat_drained", 32'(REF_PENDING), 32'd0);
    chk("sat_overrun_sticky", 32'(OVERRUN), 32'd1);

    // DONE in REF on the tick cycle, then reset mid-refresh
    AS = 1'b1; DONE = 1'b0;
    n = 0;
    while (!REF_GO && n < 40) begin cyc(); n++; end
    chk("sim_ref_grant", 32'(REF_GO), 32'd1);
    n = 0;
    while (m_cnt != RI - 1 && n < 40) begin cyc(); n++; end
    p = int'(REF_PENDING);
    DONE = 1'b1; cyc(); DONE = 1'b0;
    chk("sim_pend_same", 32'(REF_PENDING), 32'(p));
    chk("sim_ref_released", 32'(REF_GO), 32'd0);
    cyc();
    chk("sim_ref_again", 32'(REF_GO), 32'd1);
    RST = 1'b1; cyc();
    chk("rst_mid_ref", 32'(REF_GO), 32'd0);
    chk("rst_mid_pend", 32'(REF_PENDING), 32'd0);
    chk("rst_mid_ovr", 32'(OVERRUN), 32'd0);
    RST = 1'b0;

    // Randomized traffic
    slow = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) AS = ~AS;
      if (AS) begin
        if ($urandom_range(0, 1) == 1) ADDR_IN = {3'b000, 21'($urandom)};
        else ADDR_IN = 24'($urandom);
      end
      if ($urandom_range(0, 199) == 0) slow = ~slow;
      if (CPU_GO || REF_GO)
        DONE = ($urandom_range(0, slow ? 60 : 3) == 0);
      else
        DONE = ($urandom_range(0, 15) == 0);
      RST = ($urandom_range(0, 499) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
